// File: rtl/msrv32_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_ifetch_queue
// Desc     : Pipelined AHB-Lite instruction fetcher with a DEPTH-entry prefetch
//            FIFO. Optional macro MSRV32_IFQ_BYPASS_EN: empty-FIFO bypass.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_ifetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic                     ms_riscv32_mp_clk_in,
   input  logic                     ms_riscv32_mp_rst_in,
   output logic [XLEN-1:0]          ms_riscv32_mp_imaddr_out,
   output logic [1:0]               ms_riscv32_mp_instr_htrans_out,
   input  logic                     ms_riscv32_mp_instr_hready_in,
   input  logic [31:0]              ms_riscv32_mp_instr_in,
   input  logic                     ms_riscv32_mp_hresp_in,
   input  logic                     redirect_in,
   input  logic [XLEN-1:0]          redirect_pc_in,
   output logic                     instr_valid_out,
   output logic [31:0]              instr_out,
   output logic [XLEN-1:0]          instr_pc_out,
   output logic                     instr_fault_out,
   input  logic                     instr_ready_in,
   output logic [$clog2(DEPTH):0]   fifo_count_out
);

   localparam int             AW          = $clog2(DEPTH);
   localparam logic [AW:0]    c_depth     = (AW+1)'(DEPTH);
   localparam logic [1:0]     c_st_run    = 2'd0;
   localparam logic [1:0]     c_st_drain  = 2'd1;
   localparam logic [1:0]     c_st_halt   = 2'd2;

   logic [1:0]       r_state;
   logic             r_started;
   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_data_pc;
   logic             r_outstanding;
   logic [31:0]      r_mem_instr [DEPTH];
   logic [XLEN-1:0]  r_mem_pc    [DEPTH];
   logic             r_mem_fault [DEPTH];
   logic [AW-1:0]    r_rptr;
   logic [AW-1:0]    r_wptr;
   logic [AW:0]      r_count;

   logic             w_data_done;
   logic             w_push_ok;
   logic             w_err;
   logic [AW:0]      w_sum;
   logic             w_issue;
   logic             w_addr_done;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [AW-1:0]    w_head_idx;

   assign w_data_done = r_outstanding & ms_riscv32_mp_instr_hready_in;
   assign w_push_ok   = (r_state == c_st_run) & w_data_done;
   assign w_err       = w_push_ok & ms_riscv32_mp_hresp_in;
   // The outstanding data phase reserves a slot so the FIFO can never overrun.
   assign w_sum       = r_count + {{AW{1'b0}}, r_outstanding};
   assign w_issue     = r_started & ~redirect_in & ~w_err &
                        (((r_state == c_st_run) & (w_sum < c_depth)) |
                         ((r_state == c_st_drain) & ms_riscv32_mp_instr_hready_in));
   assign w_addr_done = w_issue & ms_riscv32_mp_instr_hready_in;

   assign ms_riscv32_mp_imaddr_out       = r_fetch_pc;
   assign ms_riscv32_mp_instr_htrans_out = w_issue ? 2'b10 : 2'b00;

`ifdef MSRV32_IFQ_BYPASS_EN
   assign w_bypass = w_empty & w_push_ok & ~ms_riscv32_mp_hresp_in & ~redirect_in;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_empty    = (r_count == '0);
   // When empty, point at the last popped slot so the outputs hold their value.
   assign w_head_idx = w_empty ? (r_rptr - AW'(1)) : r_rptr;
   assign w_pop      = ~w_empty & instr_ready_in;
   assign w_push     = w_push_ok & ~(w_bypass & instr_ready_in);

   assign instr_valid_out = ~w_empty | w_bypass;
   assign instr_out       = w_bypass ? ms_riscv32_mp_instr_in : r_mem_instr[w_head_idx];
   assign instr_pc_out    = w_bypass ? r_data_pc : r_mem_pc[w_head_idx];
   assign instr_fault_out = ~w_empty & r_mem_fault[w_head_idx];
   assign fifo_count_out  = r_count;

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         r_state       <= c_st_run;
         r_started     <= 1'b0;
         r_fetch_pc    <= RESET_PC;
         r_data_pc     <= RESET_PC;
         r_outstanding <= 1'b0;
         r_rptr        <= '0;
         r_wptr        <= '0;
         r_count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_instr[i] <= '0;
            r_mem_pc[i]    <= '0;
            r_mem_fault[i] <= 1'b0;
         end
      end else begin
         r_started <= 1'b1;
         if (redirect_in) begin
            r_fetch_pc    <= redirect_pc_in;
            r_outstanding <= r_outstanding & ~ms_riscv32_mp_instr_hready_in;
            r_wptr        <= r_rptr;
            r_count       <= '0;
            if (redirect_pc_in[1:0] != 2'b00) begin
               r_mem_instr[r_rptr] <= '0;
               r_mem_pc[r_rptr]    <= redirect_pc_in;
               r_mem_fault[r_rptr] <= 1'b1;
               r_wptr              <= r_rptr + AW'(1);
               r_count             <= (AW+1)'(1);
               r_state             <= c_st_halt;
            end else if (r_outstanding & ~ms_riscv32_mp_instr_hready_in) begin
               r_state <= c_st_drain;
            end else begin
               r_state <= c_st_run;
            end
         end else begin
            if (w_addr_done) begin
               r_outstanding <= 1'b1;
               r_data_pc     <= r_fetch_pc;
               r_fetch_pc    <= r_fetch_pc + XLEN'(4);
            end else if (w_data_done) begin
               r_outstanding <= 1'b0;
            end
            if (w_push) begin
               r_mem_instr[r_wptr] <= ms_riscv32_mp_instr_in;
               r_mem_pc[r_wptr]    <= r_data_pc;
               r_mem_fault[r_wptr] <= ms_riscv32_mp_hresp_in;
               r_wptr              <= r_wptr + AW'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            case (r_state)
               c_st_drain: if (ms_riscv32_mp_instr_hready_in) r_state <= c_st_run;
               c_st_run:   if (w_err) r_state <= c_st_halt;
               default:    r_state <= r_state;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
